// File: rtl/rs_alu_alloc.sv
// Entry allocator for the 16-entry ALU reservation station: grants up to two
// free entries per cycle and tracks per-entry busy state and speculation tags.
module rs_alu_alloc #(
  parameter int ENT_NUM     = 16,
  parameter int ENT_SEL     = 4,
  parameter int SPECTAG_LEN = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             req_num,
  input  logic [SPECTAG_LEN-1:0] wspectag1,
  input  logic [SPECTAG_LEN-1:0] wspectag2,
  input  logic                   issue_valid,
  input  logic [ENT_SEL-1:0]     issue_addr,
  input  logic                   prmiss,
  input  logic                   prsuccess,
  input  logic [SPECTAG_LEN-1:0] prtag,
  input  logic [SPECTAG_LEN-1:0] specfixtag,
  output logic [ENT_SEL-1:0]     waddr1,
  output logic [ENT_SEL-1:0]     waddr2,
  output logic                   we1,
  output logic                   we2,
  output logic                   alloc_stall,
  output logic [ENT_NUM-1:0]     busy_vec,
  output logic [ENT_SEL:0]       free_cnt
);

  logic [ENT_NUM-1:0]     busy;
  logic [ENT_NUM-1:0]     busy_nxt;
  logic [SPECTAG_LEN-1:0] spectag_m [ENT_NUM];
  logic [SPECTAG_LEN-1:0] tag_nxt   [ENT_NUM];
  logic [ENT_SEL-1:0]     addr1, addr2;
  logic                   found1, found2;
  logic [ENT_SEL:0]       cnt;
  logic [1:0]             eff_req;
  logic                   stall;
  logic [SPECTAG_LEN-1:0] clr_mask;

  // Free-entry scan: the two lowest-index free entries plus the free count.
  always_comb begin
    addr1  = '0;
    addr2  = '0;
    found1 = 1'b0;
    found2 = 1'b0;
    cnt    = '0;
    for (int unsigned i = 0; i < ENT_NUM; i++) begin
      if (!busy[i]) begin
        cnt = cnt + 1'b1;
        if (!found1) begin
          addr1  = ENT_SEL'(i);
          found1 = 1'b1;
        end else if (!found2) begin
          addr2  = ENT_SEL'(i);
          found2 = 1'b1;
        end
      end
    end
  end

  assign eff_req  = (req_num == 2'd3) ? 2'd0 : req_num;
  assign stall    = ({{(ENT_SEL-1){1'b0}}, eff_req} > cnt) | prmiss;
  assign busy_vec = busy;
  assign free_cnt = cnt;

  // Gated by rst so every output shows its reset value while rst is high.
  assign alloc_stall = stall & ~rst;
  assign we1         = ~rst & ~stall & (eff_req != 2'd0);
  assign we2         = ~rst & ~stall & (eff_req == 2'd2);
  assign waddr1      = rst ? '0 : addr1;
  assign waddr2      = rst ? '0 : addr2;

  // prmiss takes priority: a confirmed branch clears nothing in that cycle.
  assign clr_mask = (prsuccess & ~prmiss) ? prtag : '0;

  always_comb begin
    busy_nxt = '0;
    for (int unsigned i = 0; i < ENT_NUM; i++) begin
      logic iss, kill, a1, a2;
      iss  = issue_valid & (issue_addr == ENT_SEL'(i)) & busy[i];
      kill = prmiss & (|(spectag_m[i] & specfixtag));
      a1   = we1 & (waddr1 == ENT_SEL'(i));
      a2   = we2 & (waddr2 == ENT_SEL'(i));
      busy_nxt[i] = (busy[i] & ~iss & ~kill) | a1 | a2;
      if (a1)
        tag_nxt[i] = wspectag1 & ~clr_mask;
      else if (a2)
        tag_nxt[i] = wspectag2 & ~clr_mask;
      else
        tag_nxt[i] = spectag_m[i] & ~clr_mask;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
      for (int unsigned i = 0; i < ENT_NUM; i++)
        spectag_m[i] <= '0;
    end else begin
      busy <= busy_nxt;
      for (int unsigned i = 0; i < ENT_NUM; i++)
        spectag_m[i] <= tag_nxt[i];
    end
  end

endmodule

// File: tb/tb_rs_alu_alloc.sv
// Self-checking bench for rs_alu_alloc: directed scenarios plus randomized
// traffic compared against a queue/array reference model.
module tb_rs_alu_alloc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_num = '0;
  logic [4:0]  wspectag1 = '0, wspectag2 = '0;
  logic        issue_valid = 1'b0;
  logic [3:0]  issue_addr = '0;
  logic        prmiss = 1'b0, prsuccess = 1'b0;
  logic [4:0]  prtag = '0, specfixtag = '0;
  logic [3:0]  waddr1, waddr2;
  logic        we1, we2, alloc_stall;
  logic [15:0] busy_vec;
  logic [4:0]  free_cnt;

  int nerr = 0;
  int nchk = 0;

  // Reference model state
  bit         m_busy [16];
  logic [4:0] m_tag  [16];
  bit         e_we1, e_we2;
  int         e_a1, e_a2;

  rs_alu_alloc #(.ENT_NUM(16), .ENT_SEL(4), .SPECTAG_LEN(5)) dut (
    .clk(clk), .rst(rst), .req_num(req_num),
    .wspectag1(wspectag1), .wspectag2(wspectag2),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .prmiss(prmiss), .prsuccess(prsuccess), .prtag(prtag),
    .specfixtag(specfixtag),
    .waddr1(waddr1), .waddr2(waddr2), .we1(we1), .we2(we2),
    .alloc_stall(alloc_stall), .busy_vec(busy_vec), .free_cnt(free_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_busy();
    logic [15:0] v;
    for (int i = 0; i < 16; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      m_busy[i] = 1'b0;
      m_tag[i]  = '0;
    end
  endtask

  task automatic zero_inputs();
    req_num = '0; wspectag1 = '0; wspectag2 = '0;
    issue_valid = 1'b0; issue_addr = '0;
    prmiss = 1'b0; prsuccess = 1'b0; prtag = '0; specfixtag = '0;
  endtask

  // Drive one cycle of inputs at the falling edge and check every output.
  task automatic apply(input logic [1:0] req, input logic [4:0] t1, input logic [4:0] t2,
                       input logic iv, input logic [3:0] ia, input logic pm,
                       input logic ps, input logic [4:0] pt, input logic [4:0] sf);
    int q[$];
    int eff;
    bit e_stall;
    @(negedge clk);
    req_num = req; wspectag1 = t1; wspectag2 = t2;
    issue_valid = iv; issue_addr = ia;
    prmiss = pm; prsuccess = ps; prtag = pt; specfixtag = sf;
    #1;
    for (int i = 0; i < 16; i++) if (!m_busy[i]) q.push_back(i);
    eff     = (req == 2'd3) ? 0 : int'(req);
    e_stall = (eff > q.size()) || pm;
    e_we1   = !e_stall && eff >= 1;
    e_we2   = !e_stall && eff == 2;
    e_a1    = (q.size() > 0) ? q[0] : 0;
    e_a2    = (q.size() > 1) ? q[1] : 0;
    check("busy_vec", 32'(busy_vec), 32'(model_busy()));
    check("free_cnt", 32'(free_cnt), 32'(q.size()));
    check("alloc_stall", 32'(alloc_stall), 32'(e_stall));
    check("we1", 32'(we1), 32'(e_we1));
    check("we2", 32'(we2), 32'(e_we2));
    check("waddr1", 32'(waddr1), 32'(e_a1));
    check("waddr2", 32'(waddr2), 32'(e_a2));
  endtask

  // Advance the clock and move the model to its next state.
  task automatic tick();
    bit         nb [16];
    logic [4:0] nt [16];
    logic [4:0] clr;
    @(posedge clk);
    clr = (prsuccess && !prmiss) ? prtag : 5'd0;
    for (int i = 0; i < 16; i++) begin
      nb[i] = m_busy[i];
      nt[i] = m_tag[i] & ~clr;
      if (m_busy[i] && issue_valid && int'(issue_addr) == i) nb[i] = 1'b0;
      if (m_busy[i] && prmiss && (m_tag[i] & specfixtag) != 5'd0) nb[i] = 1'b0;
    end
    if (e_we1) begin nb[e_a1] = 1'b1; nt[e_a1] = wspectag1 & ~clr; end
    if (e_we2) begin nb[e_a2] = 1'b1; nt[e_a2] = wspectag2 & ~clr; end
    for (int i = 0; i < 16; i++) begin
      m_busy[i] = nb[i];
      m_tag[i]  = nt[i];
    end
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy_vec), 32'h0);
    check({tag, "_free"}, 32'(free_cnt), 32'd16);
    check({tag, "_stall"}, 32'(alloc_stall), 32'h0);
    check({tag, "_we"}, 32'({we1, we2}), 32'h0);
    check({tag, "_waddr"}, 32'({waddr1, waddr2}), 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    zero_inputs();
    req_num = 2'd2;
    rst = 1'b1;
    #1;
    check_reset_outputs("reset");
    model_clear();
    @(negedge clk);
    req_num = '0;
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    model_clear();
    do_reset();

    // Fill by pairs
    for (int k = 0; k < 8; k++) begin
      apply(2'd2, 5'd0, 5'd0, 1'b0, 4'd0, 1'b0, 1'b0, 5'd0, 5'd0);
      check("pair_a1", 32'(waddr1), 32'(2 * k));
      check("pair_a2", 32'(waddr2), 32'(2 * k + 1));
      tick();
    end
    check("full_busy", 32'(busy_vec), 32'hFFFF);
    check("full_free", 32'(free_cnt), 32'd0);

    // Full: request stalls; issued entry only reusable next cycle
    apply(2'd1, 5'd0, 5'd0, 1'b1, 4'd5, 1'b0, 1'b0, 5'd0, 5'd0);
    check("full_stall", 32'(alloc_stall), 32'd1);
    check("full_we1", 32'(we1), 32'd0);
    tick();
    apply(2'd1, 5'd0, 5'd0, 1'b0, 4'd0, 1'b0, 1'b0, 5'd0, 5'd0);
    check("reuse_a1", 32'(waddr1), 32'd5);
    check("reuse_we1", 32'(we1), 32'd1);
    tick();
    check("refull_busy", 32'(busy_vec), 32'hFFFF);

    // One free entry, two requested: no partial grant
    apply(2'd0, 5'd0, 5'd0, 1'b1, 4'd9, 1'b0, 1'b0, 5'd0, 5'd0);
    tick();
    apply(2'd2, 5'd0, 5'd0, 1'b0, 4'd0, 1'b0, 1'b0, 5'd0, 5'd0);
    check("one_free_stall", 32'(alloc_stall), 32'd1);
    check("one_free_we", 32'({we1, we2}), 32'd0);
    tick();
    check("one_free_busy", 32'(busy_vec), 32'hFDFF);

    // Mispredict kill by tag mask
    do_reset();
    apply(2'd2, 5'b00001, 5'b00010, 1'b0, 4'd0, 1'b0, 1'b0, 5'd0, 5'd0);
    tick();
    apply(2'd2, 5'b00010, 5'b00000, 1'b0, 4'd0, 1'b0, 1'b0, 5'd0, 5'd0);
    tick();
    apply(2'd1, 5'd0, 5'd0, 1'b0, 4'd0, 1'b1, 1'b0, 5'd0, 5'b00010);
    check("kill_stall", 32'(alloc_stall), 32'd1);
    tick();
    check("kill_busy", 32'(busy_vec), 32'h0009);

    // Confirmed branch shields entry from a later kill
    do_reset();
    apply(2'd1, 5'b00100, 5'd0, 1'b0, 4'd0, 1'b0, 1'b0, 5'd0, 5'd0);
    tick();
    apply(2'd0, 5'd0, 5'd0, 1'b0, 4'd0, 1'b0, 1'b1, 5'b00100, 5'd0);
    tick();
    apply(2'd0, 5'd0, 5'd0, 1'b0, 4'd0, 1'b1, 1'b0, 5'd0, 5'b00100);
    tick();
    check("shield_busy", 32'(busy_vec), 32'h0001);

    // Issue and kill of the same entry in one cycle
    do_reset();
    apply(2'd2, 5'b01000, 5'b01000, 1'b0, 4'd0, 1'b0, 1'b0, 5'd0, 5'd0);
    tick();
    apply(2'd0, 5'd0, 5'd0, 1'b1, 4'd1, 1'b1, 1'b0, 5'd0, 5'b01000);
    tick();
    check("iss_kill_busy", 32'(busy_vec), 32'h0000);

    // Asynchronous reset between edges
    do_reset();
    for (int k = 0; k < 4; k++) begin
      apply(2'd2, 5'd0, 5'd0, 1'b0, 4'd0, 1'b0, 1'b0, 5'd0, 5'd0);
      tick();
    end
    check("pre_rst_busy", 32'(busy_vec), 32'h00FF);
    apply(2'd2, 5'd0, 5'd0, 1'b0, 4'd0, 1'b1, 1'b0, 5'd0, 5'b11111);
    #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    model_clear();
    @(negedge clk);
    zero_inputs();
    rst = 1'b0;

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      r = $urandom;
      apply(r[1:0], r[6:2], r[11:7], r[12] | r[13], r[17:14],
            (r[21:18] == 4'd0), (r[23:22] == 2'd0),
            5'(1 << (r[26:24] % 5)), r[31:27]);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/rs_alu_alloc.md
Name: rs_alu_alloc

Overview:
- Entry allocator for the 16-entry ALU reservation station.
- Sits between dispatch and the RS entry array.
- Picks up to two free entries per cycle, drives the per-entry write addresses and write enables, and tracks entry busy state and speculation tags.
- Releases entries on issue and on branch-mispredict flush.

Parameters:
- ENT_NUM, 16, number of RS entries.
- ENT_SEL, 4, entry index width (log2 ENT_NUM).
- SPECTAG_LEN, 5, one-hot speculation tag width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_num  in  2  allocations requested this cycle: 0, 1 or 2. Value 3 is reserved and treated as 0.
- wspectag1  in  SPECTAG_LEN  spec tag for the 1st allocated entry.
- wspectag2  in  SPECTAG_LEN  spec tag for the 2nd allocated entry.
- issue_valid  in  1  select logic issued an entry this cycle.
- issue_addr  in  ENT_SEL  index of the issued entry.
- prmiss  in  1  branch mispredict resolved.
- prsuccess  in  1  branch prediction confirmed.
- prtag  in  SPECTAG_LEN  one-hot tag of the resolved branch.
- specfixtag  in  SPECTAG_LEN  mask of tags to kill on prmiss.
- waddr1  out  ENT_SEL  1st allocated entry index.
- waddr2  out  ENT_SEL  2nd allocated entry index.
- we1  out  1  write enable for waddr1.
- we2  out  1  write enable for waddr2.
- alloc_stall  out  1  request cannot be granted; dispatch holds.
- busy_vec  out  ENT_NUM  registered busy bit per entry.
- free_cnt  out  ENT_SEL+1  number of non-busy entries (0..16).

Behaviour:
- State per entry i: busy[i] and spectag_m[i] (SPECTAG_LEN). Both clear asynchronously on rst.
- Reset values:
  - busy_vec = 0, free_cnt = 16, alloc_stall = 0.
  - we1 = we2 = 0, waddr1 = waddr2 = 0.
- free_cnt: combinational popcount of ~busy_vec.
- Address selection (combinational from registered busy_vec, same cycle):
  - waddr1 = lowest-index free entry.
  - waddr2 = next lowest free entry above waddr1.
  - If no such entry exists, the address is 0.
- Stall:
  - alloc_stall = (eff_req > free_cnt) | prmiss, where eff_req = req_num, or 0 when req_num = 3.
  - Grant is all-or-nothing: on stall, we1 = we2 = 0 and no entry is allocated.
- Grant when not stalled:
  - we1 = (eff_req >= 1); we2 = (eff_req == 2).
  - Zero-latency: enables and addresses are valid in the same cycle as req_num.
- Next-state update on the rising edge, per entry i:
  - busy[i] <= (busy[i] & ~iss[i] & ~kill[i]) | alloc[i].
  - iss[i] = issue_valid & (issue_addr == i) & busy[i].
  - kill[i] = prmiss & |(spectag_m[i] & specfixtag).
  - alloc[i] = (we1 & waddr1 == i) | (we2 & waddr2 == i).
- Spec tag update:
  - On alloc, spectag_m[i] <= wspectag1 or wspectag2. If prsuccess is asserted the same cycle, the written tag is wspectagN & ~prtag.
  - Else, if prsuccess: spectag_m[i] <= spectag_m[i] & ~prtag for every entry.
  - prsuccess and prmiss asserted together: prmiss wins, and no prsuccess tag clearing occurs that cycle.
- Boundary conditions:
  - Issue of a non-busy entry is ignored.
  - Issue and kill of the same entry in one cycle clears it once, with no error.
  - Entries freed by issue or kill become allocatable the next cycle, never the same cycle.
  - Full (free_cnt = 0) with req_num = 1: stall, and busy_vec is unchanged apart from issue/kill.
  - free_cnt = 1 with req_num = 2: stall with zero grants; a partial grant is not allowed.
  - rst asserted mid-operation: all state clears immediately, independent of the clock.
  - Outputs reach their reset values in the same cycle.

Test Plan:
- Reset, then req_num=2 for 8 cycles → pairs (0,1), (2,3) … (14,15); busy_vec = 0xFFFF, free_cnt = 0.
- From full, issue_addr=5 with req_num=1 → stall that cycle, no alloc. Next cycle waddr1=5, we1=1, and busy_vec returns to 0xFFFF.
- free_cnt=1 (only entry 9 free), req_num=2 → alloc_stall=1, we1=we2=0, busy_vec unchanged.
- Allocate entries 0-3 with spectag 00001, 00010, 00010, 00000, then prmiss with specfixtag=00010 → busy_vec = 0x0009. Any req_num in that same cycle gets alloc_stall=1.
- Allocate entry 0 with tag 00100, prsuccess prtag=00100, then prmiss specfixtag=00100 → entry 0 stays busy.
- Assert rst asynchronously between clock edges while busy_vec=0x00FF → busy_vec=0 and free_cnt=16 before the next clock edge.
